// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: stage payload widths,
// the {hd_v, sk_v} state encoding and the default bubble payload.
package pipe_pkg;

    localparam int unsigned IF_ID_W = 161;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_e;

    localparam logic [IF_ID_W-1:0] BUBBLE_DEFAULT = '0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable and asynchronous active-low reset.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a 2-entry skid buffer and switch/halt/flush
// controls. Defining PIPE_STAGE_PERF_EN adds saturating stall and flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_DEFAULT),
    parameter int unsigned       CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic              halt,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    logic              r_hd_v, r_sk_v;
    logic [DATA_W-1:0] r_hd_d, r_sk_d;

    logic              w_hd_v, w_sk_v;
    logic [DATA_W-1:0] w_hd_d, w_sk_d;
    logic              w_ctl, w_acc, w_deq;
    pipe_state_e       w_state;

    // Ready depends only on registered state and controls, never on out_ready.
    assign w_ctl    = halt | switch | flush;
    assign in_ready = rst & ~r_sk_v & ~w_ctl;
    assign w_acc    = in_valid & in_ready;
    assign w_deq    = r_hd_v & out_ready & ~w_ctl;
    assign w_state  = pipe_state_e'({r_hd_v, r_sk_v});

    always_comb begin
        w_hd_v = r_hd_v;
        w_sk_v = r_sk_v;
        w_hd_d = r_hd_d;
        w_sk_d = r_sk_d;
        if (switch || (!halt && flush)) begin
            w_hd_v = 1'b0;
            w_sk_v = 1'b0;
            w_hd_d = BUBBLE;
            w_sk_d = BUBBLE;
        end else if (!halt) begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_hd_v = 1'b1;
                        w_hd_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_deq) begin
                        w_hd_d = in_data;
                    end else if (w_acc) begin
                        w_sk_v = 1'b1;
                        w_sk_d = in_data;
                    end else if (w_deq) begin
                        w_hd_v = 1'b0;
                        w_hd_d = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (w_deq) begin
                        w_hd_d = r_sk_d;
                        w_sk_v = 1'b0;
                        w_sk_d = BUBBLE;
                    end
                end
                default: begin
                    // Unreachable {0,1}: recover to EMPTY rather than stick.
                    w_hd_v = 1'b0;
                    w_sk_v = 1'b0;
                    w_hd_d = BUBBLE;
                    w_sk_d = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hd_v <= 1'b0;
            r_sk_v <= 1'b0;
            r_hd_d <= BUBBLE;
            r_sk_d <= BUBBLE;
        end else begin
            r_hd_v <= w_hd_v;
            r_sk_v <= w_sk_v;
            r_hd_d <= w_hd_d;
            r_sk_d <= w_sk_d;
        end
    end

    assign out_valid = r_hd_v;
    assign out_data  = r_hd_d;

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_hd_v & ~out_ready & ~halt),
        .o_cnt (perf_stall_cnt)
    );

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (flush | switch),
        .o_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a capacity-2 FIFO model tracks accepted entries,
// a negedge monitor compares every output against it.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned W = IF_ID_W;
    localparam logic [W-1:0] BUB = '0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sw = 1'b0, halt = 1'b0, flush = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  perf_stall_cnt, perf_flush_cnt;
    logic [31:0]  m_stall, m_flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    bit m_acc, m_deq;

    pipe_stage_reg #(
        .DATA_W (W),
        .BUBBLE (BUB),
        .CNT_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch    (sw),
        .halt      (halt),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: FIFO of depth 2; switch > halt > flush > normal.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
`ifdef PIPE_STAGE_PERF_EN
            m_stall = '0;
            m_flush = '0;
`endif
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            if (exp_q.size() > 0 && !out_ready && !halt && m_stall != '1) m_stall++;
            if ((flush || sw) && m_flush != '1) m_flush++;
`endif
            if (sw || (!halt && flush)) begin
                exp_q.delete();
            end else if (!halt) begin
                m_acc = in_valid && (exp_q.size() < 2);
                m_deq = (exp_q.size() > 0) && out_ready;
                if (m_deq) void'(exp_q.pop_front());
                if (m_acc) exp_q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        logic         e_rdy;
        logic [W-1:0] e_hd, e_sk;
        e_rdy = rst && (exp_q.size() < 2) && !halt && !sw && !flush;
        e_hd  = (exp_q.size() > 0) ? exp_q[0] : BUB;
        e_sk  = (exp_q.size() > 1) ? exp_q[1] : BUB;
        check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
        check("out_data", out_data, e_hd);
        check("in_ready", W'(in_ready), W'(e_rdy));
        check("skid_data", dut.r_sk_d, e_sk);
        check("illegal_state_01", W'(dut.r_sk_v && !dut.r_hd_v), W'(0));
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_cnt", W'(perf_stall_cnt), W'(m_stall));
        check("perf_flush_cnt", W'(perf_flush_cnt), W'(m_flush));
`endif
    end

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 6; i++) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input bit h, input bit f, input bit s);
        @(posedge clk);
        #2;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        halt      = h;
        flush     = f;
        sw        = s;
    endtask

    task automatic fill_full();
        step(1'b1, W'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, W'(32'hB), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, BUB, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Streaming 1..8 back-to-back
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-pressure, third push refused, then drain
        fill_full();
        step(1'b1, W'(32'hC), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, BUB, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, 1'b0, 1'b0);

        // Halt with FULL, then release
        fill_full();
        repeat (3) step(1'b1, W'(32'hD), 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, 1'b0, 1'b0);

        // flush&halt holds, flush empties, switch&halt empties
        fill_full();
        step(1'b1, W'(32'hE), 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, W'(32'hE), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, BUB, 1'b0, 1'b0, 1'b0, 1'b0);
        fill_full();
        step(1'b1, W'(32'hF), 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, BUB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while FULL
        fill_full();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out_valid", W'(out_valid), W'(0));
        check("async_rst_out_data", out_data, BUB);
        check("async_rst_in_ready", W'(in_ready), W'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        step(1'b0, BUB, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional controls
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 2);
        end
        repeat (4) step(1'b0, BUB, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register that replaces the hand-written per-stage registers (IF/ID, ID/EX, ...).
- Carries an opaque payload bus plus valid, with a ready/valid handshake on both sides.
- Contains a 2-entry skid buffer, so upstream ready is registered and back-pressure never drops data.
- Keeps the existing stage controls with fixed priority: switch, halt, flush.

Parameters:
- DATA_W, 161, payload width in bits (default = pc 64 + pc4 64 + ins 32 + jump 1).
- BUBBLE, {DATA_W{1'b0}}, payload value driven and stored when an entry is invalid.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- switch  in  1  context switch; clears the stage; highest synchronous priority.
- halt  in  1  global freeze; holds all state.
- flush  in  1  squash; empties the stage.
- in_valid  in  1  upstream entry valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept an entry this cycle.
- out_valid  out  1  head entry valid.
- out_data  out  DATA_W  head payload.
- out_ready  in  1  downstream accepts the head entry.

Behaviour:
- Storage: head register (hd_v, hd_d) and skid register (sk_v, sk_d). out_valid=hd_v, out_data=hd_d.
- State is encoded by {hd_v, sk_v}:
  - EMPTY = 00
  - ONE = 10
  - FULL = 11
  - 01 is illegal and must never occur; the bench asserts this.
- Reset (rst=0, asynchronous): hd_v=sk_v=0, hd_d=sk_d=BUBBLE, so out_valid=0 and out_data=BUBBLE. in_ready is 0 while rst=0.
- in_ready = rst & !sk_v & !halt & !switch & !flush. This is combinational from registered state and the control inputs only; it has no in_valid/out_ready path.
- Handshake events:
  - acc = in_valid & in_ready.
  - deq = hd_v & out_ready & !halt & !switch & !flush.
- Synchronous priority (rising edge): switch > halt > flush > normal.
  - switch=1: both entries are cleared (valid=0, data=BUBBLE). Input is dropped.
  - halt=1 (switch=0): every register holds its value. No accept, no dequeue.
  - flush=1: same effect as switch. Any in-flight input that cycle is discarded.
- Normal transitions:
  - EMPTY, acc -> ONE (hd<=in). EMPTY, no acc -> EMPTY.
  - ONE, acc & deq -> ONE (hd<=in).
  - ONE, acc & !deq -> FULL (sk<=in).
  - ONE, !acc & deq -> EMPTY (hd<=BUBBLE).
  - ONE, no event -> ONE (hold).
  - FULL, deq -> ONE (hd<=sk, sk<=BUBBLE). acc is impossible in FULL since in_ready=0.
  - FULL, !deq -> FULL (hold).
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry/cycle with out_ready held high. Order is strictly FIFO.
- Data is never modified. Invalid entries always hold BUBBLE, so a bubble decodes as a NOP, as today.
- Reset asserted mid-operation discards all content immediately, without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_stall_cnt[CNT_W] and perf_flush_cnt[CNT_W].
  - perf_stall_cnt increments each cycle with hd_v & !out_ready & !halt.
  - perf_flush_cnt increments on each cycle with flush|switch.
  - Both reset to 0 on rst and saturate at all-ones.
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage payload widths as localparams (IF_ID_W=161, etc.)
  - the 2-bit state encoding constants ST_EMPTY/ST_ONE/ST_FULL
  - a default BUBBLE constant.
- One natural sub-module: pipe_perf_cnt, a saturating counter with enable and async active-low reset, instantiated twice under the macro.

Test Plan:
- Reset: rst=0 mid-stream with FULL state -> out_valid=0, out_data=0, in_ready=0 immediately. After release, state EMPTY and in_ready=1.
- Streaming: out_ready=1, push 0x1..0x8 back-to-back -> each out_data appears 1 cycle after its accept, in order, with no gaps.
- Back-pressure: out_ready=0, push A,B -> in_ready drops after B; A stays on out_data. Raise out_ready -> A then B, none lost or duplicated.
- halt: FULL state, halt=1 for 3 cycles with out_ready=1 and in_valid=1 -> all state frozen, in_ready=0. Release -> drain resumes with A.
- flush vs halt vs switch: FULL, flush=1 & halt=1 -> state held. flush=1 alone -> EMPTY, out_data=BUBBLE, same-cycle input dropped. switch=1 & halt=1 -> EMPTY.
- PERF (macro on): 5 cycles out_valid & !out_ready, then 2 flush pulses -> perf_stall_cnt=5, perf_flush_cnt=2. With CNT_W=3 and 9 stalls -> counter saturates at 7.
